// File: rtl/decode_pipe_stage_pkg.sv
// Opcode map, instruction field positions and instruction classes for the uDLX decode stage.
package decode_pipe_stage_pkg;

  localparam logic [5:0] TYPE_R = 6'h00;
  localparam logic [5:0] JPC    = 6'h02;
  localparam logic [5:0] BEQZ   = 6'h04;
  localparam logic [5:0] BNEZ   = 6'h05;
  localparam logic [5:0] BRFL   = 6'h06;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] SUBI   = 6'h0A;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] JR     = 6'h12;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;

  localparam int OPCODE_LSB    = 26;
  localparam int RS_LSB        = 21;
  localparam int RT_LSB        = 16;
  localparam int RD_LSB        = 11;
  localparam int FUNCTION_LSB  = 0;
  localparam int PC_OFFSET_LSB = 0;
  localparam int IMM_LSB       = 0;
  localparam int IMM_WIDTH     = 16;

  typedef enum logic [2:0] {
    CLASS_NOP,
    CLASS_R,
    CLASS_I_ALU,
    CLASS_LW,
    CLASS_SW,
    CLASS_BRANCH,
    CLASS_JR,
    CLASS_JPC
  } inst_class_e;

  function automatic inst_class_e classify(input logic [5:0] opcode);
    case (opcode)
      TYPE_R:                classify = CLASS_R;
      ADDI, SUBI, ANDI, ORI: classify = CLASS_I_ALU;
      LW:                    classify = CLASS_LW;
      SW:                    classify = CLASS_SW;
      BEQZ, BNEZ, BRFL:      classify = CLASS_BRANCH;
      JR:                    classify = CLASS_JR;
      JPC:                   classify = CLASS_JPC;
      default:               classify = CLASS_NOP;
    endcase
  endfunction

  // Logical immediates are unsigned masks; every other immediate is signed.
  function automatic logic zero_extends(input logic [5:0] opcode);
    return (opcode == ANDI) || (opcode == ORI);
  endfunction

endpackage

// File: rtl/decode_pipe_stage_decode_logic.sv
// Purely combinational uDLX instruction classifier and field extractor.
module decode_logic
  import decode_pipe_stage_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int OPCODE_WIDTH      = 6,
  parameter int FUNCTION_WIDTH    = 6,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH        = 32,
  parameter int PC_OFFSET_WIDTH   = 26
) (
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [OPCODE_WIDTH-1:0]      opcode,
  output logic [FUNCTION_WIDTH-1:0]    inst_function,
  output logic [REG_ADDR_WIDTH-1:0]    read_address1,
  output logic [REG_ADDR_WIDTH-1:0]    read_address2,
  output logic [REG_ADDR_WIDTH-1:0]    w_reg_addr,
  output logic                         w_reg_wr_en,
  output logic                         mem_data_wr_en,
  output logic                         write_back_mux_sel,
  output logic                         branch_inst,
  output logic                         jump_inst,
  output logic [DATA_WIDTH-1:0]        immediate,
  output logic [PC_OFFSET_WIDTH-1:0]   pc_offset
);

  inst_class_e               inst_class;
  logic [5:0]                op_field;
  logic [REG_ADDR_WIDTH-1:0] rs_field;
  logic [REG_ADDR_WIDTH-1:0] rt_field;
  logic [REG_ADDR_WIDTH-1:0] rd_field;
  logic [IMM_WIDTH-1:0]      imm_field;
  logic [DATA_WIDTH-1:0]     imm_signed;
  logic [DATA_WIDTH-1:0]     imm_unsigned;
  logic [REG_ADDR_WIDTH-1:0] dest;
  logic                      writes_reg;

  assign op_field     = instruction[OPCODE_LSB +: 6];
  assign inst_class   = classify(op_field);
  assign rs_field     = instruction[RS_LSB +: REG_ADDR_WIDTH];
  assign rt_field     = instruction[RT_LSB +: REG_ADDR_WIDTH];
  assign rd_field     = instruction[RD_LSB +: REG_ADDR_WIDTH];
  assign imm_field    = instruction[IMM_LSB +: IMM_WIDTH];
  assign imm_signed   = {{(DATA_WIDTH-IMM_WIDTH){imm_field[IMM_WIDTH-1]}}, imm_field};
  assign imm_unsigned = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm_field};

  always_comb begin
    opcode             = '0;
    inst_function      = '0;
    read_address1      = '0;
    read_address2      = '0;
    dest               = '0;
    writes_reg         = 1'b0;
    mem_data_wr_en     = 1'b0;
    write_back_mux_sel = 1'b0;
    branch_inst        = 1'b0;
    jump_inst          = 1'b0;
    immediate          = '0;
    pc_offset          = '0;
    if (inst_class != CLASS_NOP) begin
      opcode = instruction[OPCODE_LSB +: OPCODE_WIDTH];
    end
    case (inst_class)
      CLASS_R: begin
        inst_function = instruction[FUNCTION_LSB +: FUNCTION_WIDTH];
        read_address1 = rs_field;
        read_address2 = rt_field;
        dest          = rd_field;
        writes_reg    = 1'b1;
      end
      CLASS_I_ALU, CLASS_LW: begin
        read_address1      = rs_field;
        dest               = rt_field;
        writes_reg         = 1'b1;
        write_back_mux_sel = (inst_class == CLASS_LW);
        immediate          = zero_extends(op_field) ? imm_unsigned : imm_signed;
      end
      CLASS_SW: begin
        read_address1  = rs_field;
        read_address2  = rt_field;
        mem_data_wr_en = 1'b1;
        immediate      = imm_signed;
      end
      CLASS_BRANCH: begin
        read_address1 = rs_field;
        branch_inst   = 1'b1;
        immediate     = imm_signed;
      end
      CLASS_JR: begin
        read_address1 = rs_field;
        jump_inst     = 1'b1;
        immediate     = imm_signed;
      end
      CLASS_JPC: begin
        pc_offset = instruction[PC_OFFSET_LSB +: PC_OFFSET_WIDTH];
        jump_inst = 1'b1;
      end
      default: begin
      end
    endcase
    // Register 0 is hardwired, so writes to it are dropped here.
    w_reg_addr  = dest;
    w_reg_wr_en = writes_reg && (dest != '0);
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// uDLX decode pipeline register with stall/flush and optional load-use bubble insertion.
// Optional feature macro: LOAD_USE_STALL_EN (hazard detection and bubble counter).
module decode_pipe_stage
  import decode_pipe_stage_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int OPCODE_WIDTH      = 6,
  parameter int FUNCTION_WIDTH    = 6,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH        = 32,
  parameter int PC_OFFSET_WIDTH   = 26,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  input  logic                         instruction_valid_in,
  input  logic                         stall_in,
  input  logic                         flush_in,
  output logic                         ready_out,
  output logic                         valid_out,
  output logic [OPCODE_WIDTH-1:0]      opcode_out,
  output logic [FUNCTION_WIDTH-1:0]    inst_function_out,
  output logic [REG_ADDR_WIDTH-1:0]    read_address1_out,
  output logic [REG_ADDR_WIDTH-1:0]    read_address2_out,
  output logic [REG_ADDR_WIDTH-1:0]    w_reg_addr_out,
  output logic                         w_reg_wr_en_out,
  output logic                         mem_data_wr_en_out,
  output logic                         write_back_mux_sel_out,
  output logic                         branch_inst_out,
  output logic                         jump_inst_out,
  output logic [DATA_WIDTH-1:0]        immediate_out,
  output logic [PC_OFFSET_WIDTH-1:0]   pc_offset_out,
  output logic [COUNT_WIDTH-1:0]       hazard_count_out
);

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]    opcode;
    logic [FUNCTION_WIDTH-1:0]  inst_function;
    logic [REG_ADDR_WIDTH-1:0]  read_address1;
    logic [REG_ADDR_WIDTH-1:0]  read_address2;
    logic [REG_ADDR_WIDTH-1:0]  w_reg_addr;
    logic                       w_reg_wr_en;
    logic                       mem_data_wr_en;
    logic                       write_back_mux_sel;
    logic                       branch_inst;
    logic                       jump_inst;
    logic [DATA_WIDTH-1:0]      immediate;
    logic [PC_OFFSET_WIDTH-1:0] pc_offset;
  } stage_t;

  stage_t dec;
  stage_t dec_gated;
  stage_t stage_q;
  logic   hazard;

  decode_logic #(
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
    .OPCODE_WIDTH      (OPCODE_WIDTH),
    .FUNCTION_WIDTH    (FUNCTION_WIDTH),
    .REG_ADDR_WIDTH    (REG_ADDR_WIDTH),
    .DATA_WIDTH        (DATA_WIDTH),
    .PC_OFFSET_WIDTH   (PC_OFFSET_WIDTH)
  ) u_decode_logic (
    .instruction        (instruction_in),
    .opcode             (dec.opcode),
    .inst_function      (dec.inst_function),
    .read_address1      (dec.read_address1),
    .read_address2      (dec.read_address2),
    .w_reg_addr         (dec.w_reg_addr),
    .w_reg_wr_en        (dec.w_reg_wr_en),
    .mem_data_wr_en     (dec.mem_data_wr_en),
    .write_back_mux_sel (dec.write_back_mux_sel),
    .branch_inst        (dec.branch_inst),
    .jump_inst          (dec.jump_inst),
    .immediate          (dec.immediate),
    .pc_offset          (dec.pc_offset)
  );

  // An invalid fetch slot still registers its fields but must not trigger any side effect.
  always_comb begin
    dec_gated = dec;
    if (!instruction_valid_in) begin
      dec_gated.w_reg_wr_en        = 1'b0;
      dec_gated.mem_data_wr_en     = 1'b0;
      dec_gated.write_back_mux_sel = 1'b0;
      dec_gated.branch_inst        = 1'b0;
      dec_gated.jump_inst          = 1'b0;
    end
  end

`ifdef LOAD_USE_STALL_EN
  // Decoded read addresses are 0 for classes that do not read them, and a LW only
  // sets wr_en for a non-zero destination, so the compares cannot false-match on r0.
  assign hazard = valid_out && stage_q.write_back_mux_sel && stage_q.w_reg_wr_en &&
                  instruction_valid_in &&
                  ((dec.read_address1 == stage_q.w_reg_addr) ||
                   (dec.read_address2 == stage_q.w_reg_addr));

  logic [COUNT_WIDTH-1:0] hazard_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hazard_count <= '0;
    end else if (!flush_in && !stall_in && hazard && (hazard_count != '1)) begin
      hazard_count <= hazard_count + COUNT_WIDTH'(1);
    end
  end

  assign hazard_count_out = hazard_count;
`else
  assign hazard           = 1'b0;
  assign hazard_count_out = '0;
`endif

  assign ready_out = !stall_in && !hazard && !flush_in;

  // Flush beats stall beats hazard; a bubble clears the whole stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      stage_q   <= '0;
    end else if (flush_in) begin
      valid_out <= 1'b0;
      stage_q   <= '0;
    end else if (!stall_in) begin
      if (hazard) begin
        valid_out <= 1'b0;
        stage_q   <= '0;
      end else begin
        valid_out <= instruction_valid_in;
        stage_q   <= dec_gated;
      end
    end
  end

  assign opcode_out             = stage_q.opcode;
  assign inst_function_out      = stage_q.inst_function;
  assign read_address1_out      = stage_q.read_address1;
  assign read_address2_out      = stage_q.read_address2;
  assign w_reg_addr_out         = stage_q.w_reg_addr;
  assign w_reg_wr_en_out        = stage_q.w_reg_wr_en;
  assign mem_data_wr_en_out     = stage_q.mem_data_wr_en;
  assign write_back_mux_sel_out = stage_q.write_back_mux_sel;
  assign branch_inst_out        = stage_q.branch_inst;
  assign jump_inst_out          = stage_q.jump_inst;
  assign immediate_out          = stage_q.immediate;
  assign pc_offset_out          = stage_q.pc_offset;

endmodule

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Registered, parametrised decode stage for the uDLX pipeline, sitting between the fetch stage and the execute stage. It classifies the fetched instruction, extracts register addresses, and produces extended immediates, PC offsets and control bits into a pipeline register with a valid bit. It honours downstream stall and branch flush, and detects load-use hazards, inserting a bubble and back-pressuring fetch.

## Interface
- INSTRUCTION_WIDTH, 32, instruction word width
- OPCODE_WIDTH, 6, opcode field width (bits [31:26])
- FUNCTION_WIDTH, 6, R-type function field width (bits [5:0])
- REG_ADDR_WIDTH, 5, register address width
- DATA_WIDTH, 32, width of extended immediate
- PC_OFFSET_WIDTH, 26, jump offset width (bits [25:0])
- COUNT_WIDTH, 16, hazard bubble counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- instruction_in  in  INSTRUCTION_WIDTH  fetched instruction
- instruction_valid_in  in  1  instruction_in is valid
- stall_in  in  1  downstream cannot accept; hold stage
- flush_in  in  1  branch/jump taken; discard stage contents
- ready_out  out  1  stage consumes instruction_in this cycle (combinational)
- valid_out  out  1  registered outputs carry a real instruction
- opcode_out, inst_function_out  out  OPCODE_WIDTH, FUNCTION_WIDTH  decoded fields
- read_address1_out, read_address2_out, w_reg_addr_out  out  REG_ADDR_WIDTH  rs, rt, destination
- w_reg_wr_en_out, mem_data_wr_en_out, write_back_mux_sel_out, branch_inst_out, jump_inst_out  out  1 each  control bits
- immediate_out  out  DATA_WIDTH  extended immediate
- pc_offset_out  out  PC_OFFSET_WIDTH  jump offset
- hazard_count_out  out  COUNT_WIDTH  saturating count of inserted load-use bubbles

## Operation
- Classes: R-type (rs,rt,rd=[15:11], wr_en); I-ALU ADDI/SUBI/ANDI/ORI (rs, dest=[20:16], wr_en); LW (as I-ALU plus write_back_mux_sel=1); SW (rs, read_address2=rt, mem_data_wr_en, no wr); BEQZ/BNEZ/BRFL (rs, branch); JR (rs, jump); JPC (pc_offset=[25:0], jump); any other opcode is NOP: all fields and controls 0.
- Immediate: sign-extended from [15:0] to DATA_WIDTH, except ANDI/ORI zero-extended; 0 for R-type, JPC and NOP.
- w_reg_wr_en forced 0 when destination is register 0.
- Load-use hazard: stage holds valid LW with destination R≠0, and incoming valid instruction reads R (rs for all reading classes; rt additionally for R-type and SW).
- Priority per clock edge: flush_in > stall_in > hazard > load.
  - flush: valid_out←0, all outputs←0.
  - stall: all registers hold.
  - hazard: bubble inserted (valid_out←0, controls←0); instruction_in not consumed; hazard_count_out increments, saturating at all-ones.
  - load: decoded fields registered; valid_out←instruction_valid_in; when instruction_valid_in=0 controls register as 0.
- ready_out = !stall_in && !hazard && !flush_in.

## Timing
- Reset: every registered output 0, hazard_count_out 0; asserting rst mid-operation clears immediately, without waiting for clk.
- Latency: 1 cycle from consumed instruction_in to valid_out.
- ready_out combinational from stall_in, flush_in, instruction_in and stage state; no registered path from instruction_in to ready_out.
- Hazard costs exactly one bubble: the following cycle the stage holds the bubble (not LW), so the hazard clears and the instruction is consumed.
- Hazard with stall_in=1: stall wins, no count. Hazard with flush_in=1: flush wins, no count.

## Configuration
- LOAD_USE_STALL_EN defined: hazard detection, bubble insertion and hazard_count_out as above.
- Undefined: hazard is constant 0, ready_out = !stall_in && !flush_in, hazard_count_out tied to 0; downstream forwarding handles load-use.

## Structure
- Shared package: opcode constants (TYPE_R, ADDI, SUBI, ANDI, ORI, LW, SW, BEQZ, BNEZ, BRFL, JR, JPC) and field bit positions.
- One sub-module, decode_logic: purely combinational classifier/extractor. Top holds hazard check, pipeline register and counter.

## Test plan
- ADDI r3,r1,0xFFFF, valid, no stall → next cycle valid_out=1, read_address1=1, w_reg_addr=3, immediate_out=0xFFFFFFFF, w_reg_wr_en=1.
- ORI r3,r1,0x8000 → immediate_out=0x00008000; R-type with rd=0 → w_reg_wr_en=0.
- LW r4,0(r2) then ADD r5,r4,r1 → ready_out=0 one cycle, one bubble (valid_out=0), ADD issues next, hazard_count_out=1; same with macro undefined → no bubble, count 0.
- stall_in=1 for 3 cycles with a SW in stage → outputs unchanged, ready_out=0; flush_in=1 with stall_in=1 → valid_out=0 next edge.
- Undefined opcode 0x3F → valid_out=1, all controls 0; JPC with offset 0x3FFFFFF → pc_offset_out=0x3FFFFFF, jump=1.
- rst pulsed between clock edges with valid stage → all outputs 0 before next edge.
